// File: rtl/tx_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tx_arb_pkg
//  Purpose  : Shared definitions for the UART transmit arbiter: FSM state
//             encodings and counter widths.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Watchdog counter width (covers TIMEOUT up to 65535).
  localparam int TO_CNT_W  = 16;
  // Inter-frame gap counter width (covers GAP_CYCLES up to 255).
  localparam int GAP_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/tx_arbiter_module_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick_module
//  Purpose  : Combinational round-robin picker. Finds the first set request
//             bit at or above ptr, wrapping to bit 0 if none is found.
//  Ports    : req    - request vector
//             ptr    - index with highest priority this round
//             any    - at least one request bit is set
//             winner - index of the selected requester
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick_module #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             any,
  output logic [2:0]       winner
);

  logic [N_REQ-1:0] upper;
  logic [2:0]       win_upper;
  logic [2:0]       win_all;

  // Two-pass search: lowest set bit among indices >= ptr takes priority;
  // otherwise the lowest set bit overall (the wrapped-around portion).
  always_comb begin
    upper     = '0;
    win_upper = '0;
    win_all   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      upper[i] = req[i] && (3'(i) >= ptr);
    end
    // Descending scan so the lowest matching index is the last one written.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (upper[i]) win_upper = 3'(i);
      if (req[i])   win_all   = 3'(i);
    end
    any    = |req;
    winner = (|upper) ? win_upper : win_all;
  end

endmodule
`default_nettype wire

// File: rtl/tx_arbiter_module.sv
`default_nettype none
// ============================================================================
//  Module   : tx_arbiter_module
//  Purpose  : Round-robin arbiter sharing one UART transmit path among N_REQ
//             byte sources, with an inter-frame gap and a done-pulse watchdog.
//  Ports    : CLK, RSTn    - clock, asynchronous active-low reset
//             Req_Sig      - per-requester pending flag
//             Req_Data     - per-requester byte, requester i at [8i+7:8i]
//             Ack_Sig      - one-cycle pulse when a byte is latched
//             TX_En_Sig    - enable to transmit controller, high per frame
//             TX_Data      - latched byte
//             TX_Done_Sig  - end-of-frame pulse from transmit controller
//             Grant_Id     - index of current / last granted requester
//             Busy_Sig     - high while sending or in the gap
//             Timeout_Err  - one-cycle pulse when a frame is aborted
//  Revision : 1.0 - initial release
// ============================================================================
module tx_arbiter_module #(
  parameter int N_REQ      = 4,
  parameter int TIMEOUT    = 65535,
  parameter int GAP_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [N_REQ-1:0]   Req_Sig,
  input  logic [8*N_REQ-1:0] Req_Data,
  output logic [N_REQ-1:0]   Ack_Sig,
  output logic               TX_En_Sig,
  output logic [7:0]         TX_Data,
  input  logic               TX_Done_Sig,
  output logic [2:0]         Grant_Id,
  output logic               Busy_Sig,
  output logic               Timeout_Err
);

  import tx_arb_pkg::*;

  localparam logic [TO_CNT_W-1:0]  TO_LAST  = TO_CNT_W'(TIMEOUT - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);
  localparam logic [2:0]           PTR_LAST = 3'(N_REQ - 1);

  state_t               state;
  logic [2:0]           ptr;
  logic [TO_CNT_W-1:0]  to_cnt;
  logic [GAP_CNT_W-1:0] gap_cnt;

  logic                 any_req;
  logic [2:0]           winner;
  logic [7:0]           sel_byte;
  logic [N_REQ-1:0]     grant_onehot;
  logic [2:0]           next_ptr;

  rr_pick_module #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (Req_Sig),
    .ptr    (ptr),
    .any    (any_req),
    .winner (winner)
  );

  // Byte and ack vector of the current winner, built by comparison so no
  // variable-width part-select is needed.
  always_comb begin
    sel_byte     = 8'h00;
    grant_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) == winner) begin
        sel_byte        = Req_Data[8*i +: 8];
        grant_onehot[i] = 1'b1;
      end
    end
    next_ptr = (winner == PTR_LAST) ? 3'd0 : winner + 3'd1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= ST_IDLE;
      ptr         <= 3'd0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      Ack_Sig     <= '0;
      TX_En_Sig   <= 1'b0;
      TX_Data     <= 8'h00;
      Grant_Id    <= 3'd0;
      Busy_Sig    <= 1'b0;
      Timeout_Err <= 1'b0;
    end else begin
      Ack_Sig     <= '0;
      Timeout_Err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            TX_Data   <= sel_byte;
            Grant_Id  <= winner;
            Ack_Sig   <= grant_onehot;
            ptr       <= next_ptr;
            to_cnt    <= '0;
            TX_En_Sig <= 1'b1;
            Busy_Sig  <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          // Done wins over a coincident timeout: the frame completed.
          if (TX_Done_Sig) begin
            TX_En_Sig <= 1'b0;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end else if (to_cnt == TO_LAST) begin
            Timeout_Err <= 1'b1;
            TX_En_Sig   <= 1'b0;
            gap_cnt     <= '0;
            state       <= ST_GAP;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            Busy_Sig <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          TX_En_Sig <= 1'b0;
          Busy_Sig  <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter_module.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_arbiter_module
//  Purpose  : Self-checking bench for tx_arbiter_module (N_REQ=4,
//             TIMEOUT=100, GAP_CYCLES=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_arbiter_module;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [2:0]  grant_id;
  logic        busy;
  logic        t_err;

  int checks = 0;
  int errors = 0;

  tx_arbiter_module #(
    .N_REQ      (4),
    .TIMEOUT    (100),
    .GAP_CYCLES (2)
  ) dut (
    .CLK         (clk),
    .RSTn        (rst_n),
    .Req_Sig     (req),
    .Req_Data    (req_data),
    .Ack_Sig     (ack),
    .TX_En_Sig   (tx_en),
    .TX_Data     (tx_data),
    .TX_Done_Sig (tx_done),
    .Grant_Id    (grant_id),
    .Busy_Sig    (busy),
    .Timeout_Err (t_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        done;
    logic [3:0]  ack;
    logic        en;
    logic [7:0]  txd;
    logic [2:0]  gid;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t vecs[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_ack, input logic e_en,
                           input logic [7:0] e_txd, input logic [2:0] e_gid,
                           input logic e_busy, input logic e_err);
    check({tag, ".ack"},  32'(ack),      32'(e_ack));
    check({tag, ".en"},   32'(tx_en),    32'(e_en));
    check({tag, ".data"}, 32'(tx_data),  32'(e_txd));
    check({tag, ".gid"},  32'(grant_id), 32'(e_gid));
    check({tag, ".busy"}, 32'(busy),     32'(e_busy));
    check({tag, ".err"},  32'(t_err),    32'(e_err));
  endtask

  localparam logic [31:0] D4 = 32'h13121110;

  initial begin
    logic ok;

    //            req      data          done  ack      en    txd    gid   busy  err
    vecs[0]  = '{4'b0100, 32'h00A50000, 1'b0, 4'b0100, 1'b1, 8'hA5, 3'd2, 1'b1, 1'b0};
    vecs[1]  = '{4'b0000, 32'h0,        1'b0, 4'b0000, 1'b1, 8'hA5, 3'd2, 1'b1, 1'b0};
    vecs[2]  = '{4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 8'hA5, 3'd2, 1'b1, 1'b0};
    vecs[3]  = '{4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 8'hA5, 3'd2, 1'b1, 1'b0};
    vecs[4]  = '{4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 8'hA5, 3'd2, 1'b0, 1'b0};
    vecs[5]  = '{4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 8'hA5, 3'd2, 1'b0, 1'b0};
    vecs[6]  = '{4'b1111, D4,           1'b0, 4'b1000, 1'b1, 8'h13, 3'd3, 1'b1, 1'b0};
    vecs[7]  = '{4'b1111, D4,           1'b0, 4'b0000, 1'b1, 8'h13, 3'd3, 1'b1, 1'b0};
    vecs[8]  = '{4'b1111, D4,           1'b1, 4'b0000, 1'b0, 8'h13, 3'd3, 1'b1, 1'b0};
    vecs[9]  = '{4'b1111, D4,           1'b1, 4'b0000, 1'b0, 8'h13, 3'd3, 1'b1, 1'b0};
    vecs[10] = '{4'b1111, D4,           1'b0, 4'b0000, 1'b0, 8'h13, 3'd3, 1'b0, 1'b0};
    vecs[11] = '{4'b1111, D4,           1'b0, 4'b0001, 1'b1, 8'h10, 3'd0, 1'b1, 1'b0};
    vecs[12] = '{4'b1111, D4,           1'b1, 4'b0000, 1'b0, 8'h10, 3'd0, 1'b1, 1'b0};
    vecs[13] = '{4'b1111, D4,           1'b0, 4'b0000, 1'b0, 8'h10, 3'd0, 1'b1, 1'b0};
    vecs[14] = '{4'b1111, D4,           1'b0, 4'b0000, 1'b0, 8'h10, 3'd0, 1'b0, 1'b0};
    vecs[15] = '{4'b1111, D4,           1'b0, 4'b0010, 1'b1, 8'h11, 3'd1, 1'b1, 1'b0};
    vecs[16] = '{4'b1111, D4,           1'b1, 4'b0000, 1'b0, 8'h11, 3'd1, 1'b1, 1'b0};
    vecs[17] = '{4'b0100, D4,           1'b0, 4'b0000, 1'b0, 8'h11, 3'd1, 1'b1, 1'b0};
    vecs[18] = '{4'b0001, D4,           1'b0, 4'b0000, 1'b0, 8'h11, 3'd1, 1'b0, 1'b0};
    vecs[19] = '{4'b0001, D4,           1'b0, 4'b0001, 1'b1, 8'h10, 3'd0, 1'b1, 1'b0};

    rst_n    = 1'b0;
    req      = 4'b0;
    req_data = 32'h0;
    tx_done  = 1'b0;
    tick();
    tick();
    check_all("reset", 4'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_all("idle", 4'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Cycle-by-cycle vectors: single request, spurious done, fairness,
    // request dropped before being served.
    for (int v = 0; v < 20; v++) begin
      req      = vecs[v].req;
      req_data = vecs[v].data;
      tx_done  = vecs[v].done;
      tick();
      check_all($sformatf("vec%0d", v), vecs[v].ack, vecs[v].en, vecs[v].txd,
                vecs[v].gid, vecs[v].busy, vecs[v].err);
    end

    // Watchdog: grant happened at the last vector edge; done never comes.
    req     = 4'b0000;
    tx_done = 1'b0;
    ok      = 1'b1;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (!(tx_en === 1'b1 && t_err === 1'b0)) ok = 1'b0;
    end
    check("wd_hold", 32'(ok), 32'd1);
    tick();
    check_all("wd_abort", 4'b0, 1'b0, 8'h10, 3'd0, 1'b1, 1'b1);
    req = 4'b0110;
    tick();
    check_all("wd_gap1", 4'b0, 1'b0, 8'h10, 3'd0, 1'b1, 1'b0);
    tick();
    check_all("wd_idle", 4'b0, 1'b0, 8'h10, 3'd0, 1'b0, 1'b0);
    tick();
    check_all("wd_next", 4'b0010, 1'b1, 8'h11, 3'd1, 1'b1, 1'b0);

    // Coincidence: done arrives in the cycle the counter is at TIMEOUT-1.
    req = 4'b0000;
    ok  = 1'b1;
    for (int i = 0; i < 99; i++) begin
      tick();
      if (!(tx_en === 1'b1 && t_err === 1'b0)) ok = 1'b0;
    end
    check("co_hold", 32'(ok), 32'd1);
    tx_done = 1'b1;
    tick();
    check_all("co_done", 4'b0, 1'b0, 8'h11, 3'd1, 1'b1, 1'b0);
    tx_done = 1'b0;
    tick();
    check_all("co_gap", 4'b0, 1'b0, 8'h11, 3'd1, 1'b1, 1'b0);
    tick();
    check_all("co_idle", 4'b0, 1'b0, 8'h11, 3'd1, 1'b0, 1'b0);

    // Reset in the middle of a frame; pointer must restart at 0.
    req = 4'b1111;
    tick();
    check_all("rs_grant", 4'b0100, 1'b1, 8'h12, 3'd2, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_all("rs_async", 4'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_all("rs_after", 4'b0001, 1'b1, 8'h10, 3'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
